alu_exec_unit: RTL

- Execute stage directly downstream of the ALU control decoder. It consumes the 4-bit ALU control code and two RV32I operands, and produces a registered result plus a zero flag for the branch and writeback logic.
- Non-shift ops complete in 1 cycle.
- Shifts use a serial 1-bit/cycle shifter to save area; the optional macro swaps in a barrel shifter.
- Valid/ready handshake on both sides, so the core can stall.

---
 rtl/alu_pkg.sv | 38 +++
 rtl/alu_serial_shifter.sv | 66 ++++++
 rtl/alu_exec_unit.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: control codes, default widths, FSM states and
// serial-shift direction encoding. Imported by the execute unit, its
// serial shifter and the upstream ALU control decoder.
package alu_pkg;

  localparam int unsigned XLEN_DEF    = 32;
  localparam int unsigned SHAMT_W_DEF = 5;
  localparam int unsigned CTRL_W      = 4;

  localparam logic [CTRL_W-1:0] ALU_ADD  = 4'b0000;
  localparam logic [CTRL_W-1:0] ALU_SUB  = 4'b0001;
  localparam logic [CTRL_W-1:0] ALU_SLL  = 4'b0010;
  localparam logic [CTRL_W-1:0] ALU_SLT  = 4'b0011;
  localparam logic [CTRL_W-1:0] ALU_SLTU = 4'b0100;
  localparam logic [CTRL_W-1:0] ALU_XOR  = 4'b0101;
  localparam logic [CTRL_W-1:0] ALU_SRL  = 4'b0110;
  localparam logic [CTRL_W-1:0] ALU_SRA  = 4'b0111;
  localparam logic [CTRL_W-1:0] ALU_OR   = 4'b1000;
  localparam logic [CTRL_W-1:0] ALU_AND  = 4'b1001;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    DIR_SLL = 2'd0,
    DIR_SRL = 2'd1,
    DIR_SRA = 2'd2
  } shift_dir_t;

  // True for the three shift control codes.
  function automatic logic is_shift_op(input logic [CTRL_W-1:0] ctrl);
    return (ctrl == ALU_SLL) || (ctrl == ALU_SRL) || (ctrl == ALU_SRA);
  endfunction

endpackage

// File: rtl/alu_serial_shifter.sv
// Serial 1-bit-per-cycle shifter used by alu_exec_unit.
// Ports:
//   clk, rst_n   clock, async active-low reset (clears acc/cnt/busy)
//   start        load op_in/shamt/dir (only issued with shamt != 0)
//   dir          shift direction (SLL/SRL/SRA)
//   op_in        value to shift
//   shamt        number of 1-bit steps
//   busy         a shift is in progress (registered)
//   done_c       this edge performs the final step
//   result_c     acc shifted by one more bit (final value when done_c)
module alu_serial_shifter
  import alu_pkg::*;
#(
  parameter int unsigned XLEN    = XLEN_DEF,
  parameter int unsigned SHAMT_W = SHAMT_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  shift_dir_t         dir,
  input  logic [XLEN-1:0]    op_in,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               busy,
  output logic               done_c,
  output logic [XLEN-1:0]    result_c
);

  logic [XLEN-1:0]    acc_q;
  logic [SHAMT_W-1:0] cnt_q;
  shift_dir_t         dir_q;

  // One-bit step of the accumulator in the latched direction.
  always_comb begin
    result_c = acc_q;
    case (dir_q)
      DIR_SLL: result_c = {acc_q[XLEN-2:0], 1'b0};
      DIR_SRL: result_c = {1'b0, acc_q[XLEN-1:1]};
      DIR_SRA: result_c = {acc_q[XLEN-1], acc_q[XLEN-1:1]};
      default: result_c = acc_q;
    endcase
  end

  assign done_c = busy && (cnt_q == SHAMT_W'(1));

  // Accumulator, step counter and direction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      cnt_q <= '0;
      dir_q <= DIR_SLL;
      busy  <= 1'b0;
    end else if (start) begin
      acc_q <= op_in;
      cnt_q <= shamt;
      dir_q <= dir;
      busy  <= 1'b1;
    end else if (busy) begin
      acc_q <= result_c;
      cnt_q <= cnt_q - SHAMT_W'(1);
      if (cnt_q == SHAMT_W'(1)) begin
        busy <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// RV32I execute stage: takes a 4-bit ALU control code and two operands with a
// valid/ready handshake, produces a registered result and zero flag.
// Non-shift ops (and shifts by 0) finish at the accept edge; shifts by k>=1
// use the serial shifter and finish k edges later.
// Build option: define ALU_EXEC_FAST_SHIFT_EN to replace the serial shifter
// with a combinational barrel shifter (every op single-cycle, same results).
// Ports:
//   clk, rst_n            clock, async active-low reset
//   in_valid / in_ready   input handshake (in_ready is combinational on out_ready)
//   alu_ctrl, op_a, op_b  operation and operands, sampled at accept
//   out_valid / out_ready output handshake
//   result, zero          registered result and (result == 0)
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int unsigned XLEN    = XLEN_DEF,
  parameter int unsigned SHAMT_W = SHAMT_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] alu_ctrl,
  input  logic [XLEN-1:0]   op_a,
  input  logic [XLEN-1:0]   op_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   result,
  output logic              zero
);

  state_t             state_q, state_d;
  logic               load_res;
  logic [XLEN-1:0]    res_d;
  logic [XLEN-1:0]    comb_res_c;
  logic [SHAMT_W-1:0] shamt_c;
  logic               accept_c;
  logic               ready_base_c;

  assign shamt_c      = op_b[SHAMT_W-1:0];
  assign ready_base_c = (state_q == IDLE) || ((state_q == DONE) && out_ready);
  assign accept_c     = in_valid && in_ready;

  // Single-cycle ALU; shifts here are only used for shamt==0 in the serial build.
  always_comb begin
    comb_res_c = op_a + op_b;
    case (alu_ctrl)
      ALU_ADD:  comb_res_c = op_a + op_b;
      ALU_SUB:  comb_res_c = op_a - op_b;
      ALU_SLL:  comb_res_c = op_a << shamt_c;
      ALU_SLT:  comb_res_c = XLEN'($signed(op_a) < $signed(op_b));
      ALU_SLTU: comb_res_c = XLEN'(op_a < op_b);
      ALU_XOR:  comb_res_c = op_a ^ op_b;
      ALU_SRL:  comb_res_c = op_a >> shamt_c;
      ALU_SRA:  comb_res_c = $unsigned($signed(op_a) >>> shamt_c);
      ALU_OR:   comb_res_c = op_a | op_b;
      ALU_AND:  comb_res_c = op_a & op_b;
      default:  comb_res_c = op_a + op_b;
    endcase
  end

`ifdef ALU_EXEC_FAST_SHIFT_EN

  assign in_ready = ready_base_c;

  // Next state: every accepted op completes at the accept edge.
  always_comb begin
    state_d  = state_q;
    load_res = 1'b0;
    res_d    = comb_res_c;
    case (state_q)
      IDLE, DONE: begin
        if (accept_c) begin
          load_res = 1'b1;
          state_d  = DONE;
        end else if ((state_q == DONE) && out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`else

  logic            shift_start_c;
  logic            shift_busy;
  logic            shift_done_c;
  logic [XLEN-1:0] shift_res_c;
  shift_dir_t      shift_dir_c;

  // Busy gating is redundant with state SHIFT; kept as a guard against
  // accepting while the shifter still owns its accumulator.
  assign in_ready = ready_base_c && !shift_busy;

  always_comb begin
    case (alu_ctrl)
      ALU_SLL: shift_dir_c = DIR_SLL;
      ALU_SRL: shift_dir_c = DIR_SRL;
      default: shift_dir_c = DIR_SRA;
    endcase
  end

  alu_serial_shifter #(
    .XLEN    (XLEN),
    .SHAMT_W (SHAMT_W)
  ) u_shifter (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (shift_start_c),
    .dir      (shift_dir_c),
    .op_in    (op_a),
    .shamt    (shamt_c),
    .busy     (shift_busy),
    .done_c   (shift_done_c),
    .result_c (shift_res_c)
  );

  // Next state: nonzero shifts go through SHIFT, everything else to DONE.
  always_comb begin
    state_d       = state_q;
    load_res      = 1'b0;
    res_d         = comb_res_c;
    shift_start_c = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (accept_c) begin
          if (is_shift_op(alu_ctrl) && (shamt_c != '0)) begin
            shift_start_c = 1'b1;
            state_d       = SHIFT;
          end else begin
            load_res = 1'b1;
            state_d  = DONE;
          end
        end else if ((state_q == DONE) && out_ready) begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        if (shift_done_c) begin
          load_res = 1'b1;
          res_d    = shift_res_c;
          state_d  = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`endif

  // State, result, zero flag and out_valid registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      result    <= '0;
      zero      <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      state_q   <= state_d;
      out_valid <= (state_d == DONE);
      if (load_res) begin
        result <= res_d;
        zero   <= (res_d == '0);
      end
    end
  end

endmodule
